// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

    localparam int ARB_W = 16;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision for the arbiter: fixed D-cache priority with an I-cache
// starvation guard, plus the starve counter that backs the guard.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic gnt_valid,
    output logic gnt_owner
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    // Priority decision; only meaningful while the arbiter sits in IDLE
    always_comb begin
        gnt_valid = 1'b0;
        gnt_owner = OWN_I;
        if (!arb_en) begin
            gnt_valid = 1'b0;
        end else if (d_req && (starve_cnt_q < LIM)) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_D;
        end else if (i_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_I;
        end else if (d_req) begin
            gnt_valid = 1'b1;
            gnt_owner = OWN_D;
        end else begin
            gnt_valid = 1'b0;
        end
    end

    // Starve counter next value; with i_req high in IDLE a grant always happens
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!arb_en) begin
            starve_cnt_d = starve_cnt_q;
        end else if (!i_req) begin
            starve_cnt_d = 4'd0;
        end else if (gnt_owner == OWN_I) begin
            starve_cnt_d = 4'd0;
        end else begin
            starve_cnt_d = sat_inc4(starve_cnt_q, LIM);
        end
    end

    // Starve counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache word transactions onto one fixed-latency
// memory port. Optional performance counters are built with MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic [15:0] mem_rdata,
    output logic        gnt_d,
    output logic        busy,
    output logic [15:0] perf_i_gnt,
    output logic [15:0] perf_d_gnt,
    output logic [15:0] perf_conflict
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [ARB_W-1:0] addr_q, addr_d;
    logic [ARB_W-1:0] wdata_q, wdata_d;
    logic [ARB_W-1:0] rdata_q, rdata_d;
    logic [3:0]       lat_q, lat_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             busy_q, busy_d;
    logic             gnt_valid;
    logic             gnt_owner;

    mem_arb_pick #(
        .STARVE_LIM (STARVE_LIM)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (state_q == IDLE),
        .i_req     (i_req),
        .d_req     (d_req),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    // Transaction sequencing; outputs are precomputed from the next state so they leave flops
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    if (gnt_owner == OWN_D) begin
                        wr_d    = d_wr;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = 16'h0000;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_stall) begin
                    state_d = ISSUE;
                end else if (wr_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            WAIT: begin
                if (lat_q == 4'd0) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_rd_d = (state_d == ISSUE) && !wr_d;
        mem_wr_d = (state_d == ISSUE) && wr_d;
        i_done_d = (state_d == DONE) && (owner_d == OWN_I);
        d_done_d = (state_d == DONE) && (owner_d == OWN_D);
        busy_d   = (state_d != IDLE);
    end

    // State, latched request and registered outputs; reset drops any in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            wr_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            lat_q    <= 4'd0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            lat_q    <= lat_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_i_q, perf_i_d;
    logic [15:0] perf_d_q, perf_d_d;
    logic [15:0] perf_c_q, perf_c_d;

    // Wrapping grant and conflict counters
    always_comb begin
        perf_i_d = perf_i_q;
        perf_d_d = perf_d_q;
        perf_c_d = perf_c_q;
        if (gnt_valid && (gnt_owner == OWN_I)) begin
            perf_i_d = perf_i_q + 16'd1;
        end else if (gnt_valid) begin
            perf_d_d = perf_d_q + 16'd1;
        end else begin
            perf_i_d = perf_i_q;
        end
        if ((state_q == IDLE) && i_req && d_req) begin
            perf_c_d = perf_c_q + 16'd1;
        end else begin
            perf_c_d = perf_c_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_q <= 16'h0000;
            perf_d_q <= 16'h0000;
            perf_c_q <= 16'h0000;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_i_gnt    = perf_i_q;
    assign perf_d_gnt    = perf_d_q;
    assign perf_conflict = perf_c_q;
`else
    assign perf_i_gnt    = 16'h0000;
    assign perf_d_gnt    = 16'h0000;
    assign perf_conflict = 16'h0000;
`endif

    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign rdata     = rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign gnt_d     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model,
// fixed-latency memory model, directed scenarios and randomized traffic.
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_LIM = 4;
`ifdef MEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_stall = 1'b0;
    logic [15:0] i_addr = 16'h0, d_addr = 16'h0, d_wdata = 16'h0, mem_rdata = 16'h0;
    logic        i_done, d_done, mem_rd, mem_wr, gnt_d, busy;
    logic [15:0] rdata, mem_addr, mem_wdata, perf_i_gnt, perf_d_gnt, perf_conflict;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .gnt_d(gnt_d), .busy(busy), .perf_i_gnt(perf_i_gnt), .perf_d_gnt(perf_d_gnt),
        .perf_conflict(perf_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: written words overlay a fixed address-derived pattern
    logic [15:0] mem [logic [15:0]];
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    bit          mm_pend = 1'b0;
    int          mm_rem = 0;
    logic [15:0] mm_addr = 16'h0;

    // Memory returns read data only during the single cycle acceptance+MEM_LAT
    always begin
        @(posedge clk);
        #1;
        if (mm_pend) begin
            if (mm_rem == 0) mm_pend = 1'b0;
            else mm_rem--;
        end
        mem_rdata = (mm_pend && mm_rem == 0) ? mem_val(mm_addr) : 16'($urandom);
    end

    // Reference model state (transaction timeline, not a state machine copy)
    bit          m_free = 1'b1, m_own_d = 1'b0, m_wr = 1'b0, m_acc = 1'b0;
    logic [15:0] m_addr = 16'h0, m_wdata = 16'h0, m_exp = 16'h0, m_hold = 16'h0;
    logic [15:0] m_pi = 16'h0, m_pd = 16'h0, m_pc = 16'h0;
    int          m_done_cyc = 0, m_starve = 0;

    // Event log for the directed scenarios
    int          i_done_cnt = 0, d_done_cnt = 0, last_i_cyc = 0, last_d_cyc = 0;
    int          wr_cyc_cnt = 0, first_rd_cyc = -1;
    logic [15:0] last_rdata = 16'h0;

    always @(negedge clk) begin
        bit fin, e_rd, e_wr, e_id, e_dd, g_ok, g_d;
        if (rst) begin
            m_free = 1'b1; m_starve = 0; m_hold = 16'h0; mm_pend = 1'b0;
            m_pi = 16'h0; m_pd = 16'h0; m_pc = 16'h0;
            chk("outputs_in_reset", 64'({i_done, d_done, rdata, mem_rd, mem_wr, mem_addr,
                mem_wdata, gnt_d, busy}), 64'd0);
            chk("perf_in_reset", 64'({perf_i_gnt, perf_d_gnt, perf_conflict}), 64'd0);
        end else begin
            fin = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_id = 1'b0; e_dd = 1'b0;
            chk("perf_i_gnt", 64'(perf_i_gnt), PERF ? 64'(m_pi) : 64'd0);
            chk("perf_d_gnt", 64'(perf_d_gnt), PERF ? 64'(m_pd) : 64'd0);
            chk("perf_conflict", 64'(perf_conflict), PERF ? 64'(m_pc) : 64'd0);
            chk("busy", 64'(busy), 64'(!m_free));
            if (!m_free) begin
                chk("gnt_d", 64'(gnt_d), 64'(m_own_d));
                if (!m_acc) begin
                    e_rd = !m_wr;
                    e_wr = m_wr;
                    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                    if (m_wr) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                    if (!mem_stall) begin
                        m_acc = 1'b1;
                        m_done_cyc = cyc + (m_wr ? 1 : MEM_LAT + 1);
                        if (!m_wr) m_exp = mem_val(m_addr);
                    end
                end else if (cyc == m_done_cyc) begin
                    e_id = !m_own_d;
                    e_dd = m_own_d;
                    if (!m_wr) m_hold = m_exp;
                    chk("rdata", 64'(rdata), 64'(m_hold));
                    fin = 1'b1;
                end
            end
            chk("mem_rd", 64'(mem_rd), 64'(e_rd));
            chk("mem_wr", 64'(mem_wr), 64'(e_wr));
            chk("i_done", 64'(i_done), 64'(e_id));
            chk("d_done", 64'(d_done), 64'(e_dd));

            if (mem_wr && !mem_stall) mem[mem_addr] = mem_wdata;
            if (mem_rd && !mem_stall) begin
                mm_pend = 1'b1; mm_rem = MEM_LAT; mm_addr = mem_addr;
            end
            if (mem_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (mem_wr) wr_cyc_cnt++;
            if (i_done) begin i_done_cnt++; last_i_cyc = cyc; last_rdata = rdata; end
            if (d_done) begin d_done_cnt++; last_d_cyc = cyc; last_rdata = rdata; end

            if (m_free) begin
                if (i_req && d_req) m_pc = m_pc + 16'd1;
                g_ok = 1'b1; g_d = 1'b0;
                if (d_req && m_starve < STARVE_LIM) g_d = 1'b1;
                else if (i_req) g_d = 1'b0;
                else if (d_req) g_d = 1'b1;
                else g_ok = 1'b0;
                if (!i_req || !g_d) m_starve = 0;
                else if (m_starve < STARVE_LIM) m_starve++;
                if (g_ok) begin
                    m_free = 1'b0; m_acc = 1'b0; m_own_d = g_d;
                    m_wr = g_d && d_wr;
                    m_addr = g_d ? d_addr : i_addr;
                    m_wdata = d_wdata;
                    if (g_d) m_pd = m_pd + 16'd1;
                    else m_pi = m_pi + 16'd1;
                end
            end else if (fin) begin
                m_free = 1'b1;
            end
        end
    end

    task automatic wait_done(input bit is_d, input int prev);
        int k;
        for (k = 0; k < 100; k++) begin
            step();
            if ((is_d ? d_done_cnt : i_done_cnt) > prev) break;
        end
        chk(is_d ? "d_done_timeout" : "i_done_timeout", 64'(k < 100), 64'd1);
    endtask

    initial begin
        int t0, ip, dp, ipv, dpv, k;
        rst = 1'b1;
        mem[16'h0040] = 16'hBEEF;
        step();
        step();
        chk("reset_state", 64'({i_done, d_done, rdata, mem_rd, mem_wr, mem_addr,
            mem_wdata, gnt_d, busy}), 64'd0);
        rst = 1'b0;
        step();

        // Starvation: D held with back-to-back reads while I waits
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'($urandom);
        i_req = 1'b1; i_addr = 16'h0040;
        ip = i_done_cnt; dp = d_done_cnt; dpv = d_done_cnt;
        for (k = 0; k < 200; k++) begin
            step();
            if (d_done_cnt != dpv) begin d_addr = 16'($urandom); dpv = d_done_cnt; end
            if (i_done_cnt > ip) break;
        end
        chk("starve_i_served", 64'(k < 200), 64'd1);
        i_req = 1'b0;
        chk("starve_d_before_i", 64'(d_done_cnt - dp), 64'd4);
        chk("starve_perf_d", 64'(perf_d_gnt), PERF ? 64'd4 : 64'd0);
        chk("starve_perf_i", 64'(perf_i_gnt), PERF ? 64'd1 : 64'd0);
        chk("starve_perf_conflict", 64'(perf_conflict), PERF ? 64'd5 : 64'd0);
        wait_done(1'b1, d_done_cnt);
        d_req = 1'b0;
        chk("starve_d_resumes", 64'(last_d_cyc - last_i_cyc), 64'd5);
        step(); step();

        // Single I read, no stall
        first_rd_cyc = -1; ip = i_done_cnt;
        i_req = 1'b1; i_addr = 16'h0040; t0 = cyc;
        wait_done(1'b0, ip);
        i_req = 1'b0;
        chk("iread_rd_cycle", 64'(first_rd_cyc - t0), 64'd1);
        chk("iread_done_cycle", 64'(last_i_cyc - t0), 64'd4);
        chk("iread_rdata", 64'(last_rdata), 64'hBEEF);
        step(); step();

        // D write stalled for three cycles
        mem_stall = 1'b1; wr_cyc_cnt = 0; ip = i_done_cnt; dp = d_done_cnt;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1234; d_wdata = 16'h00FF; t0 = cyc;
        repeat (4) step();
        mem_stall = 1'b0;
        wait_done(1'b1, dp);
        d_req = 1'b0; d_wr = 1'b0;
        chk("wr_strobe_cycles", 64'(wr_cyc_cnt), 64'd4);
        chk("wr_done_cycle", 64'(last_d_cyc - t0), 64'd5);
        chk("wr_no_i_done", 64'(i_done_cnt), 64'(ip));
        step(); step();

        // Simultaneous requests: D first, I granted right after d_done
        ip = i_done_cnt; dp = d_done_cnt;
        d_req = 1'b1; d_addr = 16'h0040; i_req = 1'b1; i_addr = 16'h1234; t0 = cyc;
        wait_done(1'b1, dp);
        d_req = 1'b0;
        chk("both_d_rdata", 64'(last_rdata), 64'hBEEF);
        wait_done(1'b0, ip);
        i_req = 1'b0;
        chk("both_d_done_cycle", 64'(last_d_cyc - t0), 64'd4);
        chk("both_i_after_d", 64'(last_i_cyc - last_d_cyc), 64'd5);
        chk("both_i_rdata", 64'(last_rdata), 64'h00FF);
        step(); step();

        // Reset in the middle of a read's WAIT phase
        ip = i_done_cnt;
        i_req = 1'b1; i_addr = 16'h0040;
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", 64'({i_done, d_done, rdata, mem_rd, mem_wr, mem_addr,
            mem_wdata, gnt_d, busy}), 64'd0);
        i_req = 1'b0;
        step();
        #2 rst = 1'b0;
        repeat (6) step();
        chk("midreset_no_done", 64'(i_done_cnt), 64'(ip));
        i_req = 1'b1; t0 = cyc;
        wait_done(1'b0, ip);
        i_req = 1'b0;
        chk("postreset_done_cycle", 64'(last_i_cyc - t0), 64'd4);
        chk("postreset_rdata", 64'(last_rdata), 64'hBEEF);
        step(); step();

        // Randomized traffic with random stalls
        ipv = i_done_cnt; dpv = d_done_cnt;
        for (int n = 0; n < 3000; n++) begin
            step();
            mem_stall = ($urandom_range(3, 0) == 0);
            if (i_done_cnt != ipv) begin ipv = i_done_cnt; i_req = 1'b0; end
            if (d_done_cnt != dpv) begin dpv = d_done_cnt; d_req = 1'b0; end
            if (!i_req && $urandom_range(2, 0) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom_range(31, 0));
            end
            if (!d_req && $urandom_range(2, 0) == 0) begin
                d_req = 1'b1; d_wr = 1'($urandom_range(1, 0));
                d_addr = 16'($urandom_range(31, 0)); d_wdata = 16'($urandom);
            end
        end
        i_req = 1'b0; d_req = 1'b0; mem_stall = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified main-memory port between the I-cache and D-cache miss/writeback engines in proc_hier.
- Serialises one word transaction at a time and sequences the issue/wait/return phases against a fixed-latency memory.
- Uses fixed D-cache priority with a starvation guard so instruction fetch always progresses.
- Sits between the two cache controllers and the memory instance inside mem_system.

Parameters:
- MEM_LAT, 2, cycles from memory accepting a read to mem_data_out being valid (legal range 1..15).
- STARVE_LIM, 4, consecutive D-cache grants allowed while an I-cache request waits (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- i_req  in  1  I-cache request; held until i_done.
- i_addr  in  16  I-cache word address.
- i_done  out  1  one-cycle completion pulse to the I-cache.
- d_req  in  1  D-cache request; held until d_done.
- d_wr  in  1  D-cache request is a write (1) or read (0).
- d_addr  in  16  D-cache address.
- d_wdata  in  16  D-cache write data.
- d_done  out  1  one-cycle completion pulse to the D-cache.
- rdata  out  16  read data; valid while i_done or d_done is high.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_stall  in  1  memory busy; a strobe is accepted only when mem_stall=0.
- mem_rdata  in  16  memory read data.
- gnt_d  out  1  current owner is the D-cache (valid outside IDLE).
- busy  out  1  state is not IDLE.
- perf_i_gnt  out  16  I grant count (feature only).
- perf_d_gnt  out  16  D grant count (feature only).
- perf_conflict  out  16  conflict-cycle count (feature only).

Behaviour:
- Reset values: all outputs 0, state IDLE, starve_cnt 0. Reset is asynchronous and may be asserted mid-transaction; the outstanding read is discarded and no done pulse is generated.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If d_req and starve_cnt<STARVE_LIM: grant D.
  - Else if i_req: grant I.
  - Else if d_req (starve limit reached with no I pending): grant D.
  - Latch owner, addr, wr and wdata into registers, then go to ISSUE. Requester inputs are not sampled again until the next IDLE.
- ISSUE:
  - Drive mem_rd or mem_wr with the latched addr/wdata; strobes are registered-state outputs.
  - If mem_stall=1: hold the strobe, stay in ISSUE.
  - If mem_stall=0 (acceptance cycle a): a write goes to DONE; a read goes to WAIT with lat_cnt=MEM_LAT-1.
- WAIT:
  - Decrement lat_cnt.
  - In the cycle where lat_cnt==0, which is cycle a+MEM_LAT, capture mem_rdata into rdata and go to DONE.
- DONE:
  - Pulse the owner's done for exactly one cycle; rdata is held valid (writes leave rdata unchanged).
  - Then go to IDLE.
- Latency:
  - Read: req seen in IDLE at cycle t with no stall gives done at t+MEM_LAT+2.
  - Write: done at t+2.
  - A new grant is made the cycle after DONE at the earliest.
- starve_cnt:
  - Increments on each D grant made while i_req=1, saturating at STARVE_LIM.
  - Clears on any I grant, or when i_req=0 in IDLE.
- I-cache transactions are always reads; a write strobe is never issued for an I grant.
- A requester dropping req before its done is a protocol violation. The transaction still completes and done still pulses.
- Both req high in IDLE with starve_cnt<STARVE_LIM: D wins; I is served the very next arbitration if D has dropped d_req.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- With the macro defined:
  - perf_i_gnt and perf_d_gnt increment on each grant.
  - perf_conflict increments on each IDLE cycle where i_req and d_req are both 1.
  - All three are 16-bit wrapping counters cleared by rst.
- Without the macro: the counters are not instantiated and the three ports are tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE}, 2 bits;
  - owner constants OWN_I=0, OWN_D=1;
  - address/data width constant 16.
- Sub-module mem_arb_pick: combinational priority decision plus the starve_cnt register; outputs the grant decision and gnt_valid.

Test Plan:
- Single I read, MEM_LAT=2, no stall, mem_rdata=0xBEEF for addr 0x0040: i_req at cycle 0 -> mem_rd high in cycle 1, i_done in cycle 4 with rdata=0xBEEF.
- D write to addr 0x1234 with data 0x00FF while mem_stall=1 for 3 cycles: mem_wr held for 4 cycles with stable addr/data -> d_done exactly 1 cycle after acceptance, no i_done.
- i_req and d_req asserted together: D is served first; d_done precedes i_done, and the second grant comes the cycle after d_done.
- d_req held continuously (back-to-back reads) with i_req high, STARVE_LIM=4 -> exactly 4 D grants, then 1 I grant, then D resumes.
- rst asserted during WAIT of a read -> all outputs 0 immediately, no done pulse, next request completes normally.
- With MEM_ARB_PERF_EN defined, run the starvation scenario above -> perf_d_gnt=4, perf_i_gnt=1, perf_conflict counts every simultaneous-request IDLE cycle; without the macro all three read 0.
